// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master arbiter: byte width and FSM states.
package spi_pkg;

  localparam int BYTE_W = 8;

  // Sequencer states: one byte = LOAD -> WAIT_LO -> WAIT_HI -> CAP.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    WAIT_LO = 3'd2,
    WAIT_HI = 3'd3,
    CAP     = 3'd4
  } state_t;

endpackage

// File: rtl/rr_arb_m.sv
// Round-robin pick: first asserted request at or after ptr, wrapping.
// Purely combinational; the pointer register lives in the caller.
module rr_arb_m #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] win_oh,
  output logic [IDX_W-1:0] win_idx,
  output logic             win_vld
);

  // Scan requesters starting at ptr; the first hit wins.
  always_comb begin
    int j;
    win_oh  = '0;
    win_idx = '0;
    win_vld = 1'b0;
    j       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!win_vld && req[j]) begin
        win_vld    = 1'b1;
        win_idx    = IDX_W'(j);
        win_oh[j]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_arb_m.sv
// Shares one SPI master between N_REQ requesters and sequences multi-byte
// transfers on it, one START per byte, completion tracked on the master's CS.
//
// Client handshake: a requester raises REQ (level) with LEN and its first
// byte on TX_DATA. GNT stays one-hot for the whole transaction. Each TX_ACK
// pulse means the current TX_DATA byte was taken; the next byte must be on
// TX_DATA by the following cycle. Every RX_VALID pulse carries one received
// byte on RX_DATA. DONE pulses once at the end; ERR pulses with it when the
// transaction was rejected (LEN=0) or aborted (CS timeout). REQ of the
// granted requester is not looked at again until DONE.
module spi_arb_m
  import spi_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int LEN_W   = 3,
  parameter int TIMEOUT = 64
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [N_REQ-1:0]        REQ,
  input  logic [N_REQ*LEN_W-1:0]  LEN,
  input  logic [N_REQ*BYTE_W-1:0] TX_DATA,
  output logic [N_REQ-1:0]        GNT,
  output logic                    TX_ACK,
  output logic [BYTE_W-1:0]       RX_DATA,
  output logic                    RX_VALID,
  output logic                    DONE,
  output logic                    ERR,
  output logic                    M_START,
  output logic [BYTE_W-1:0]       M_DOUT,
  input  logic [BYTE_W-1:0]       M_DIN,
  input  logic                    M_CS,
  output state_t                  dbg_state
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   ptr, ptr_nxt;
  logic [IDX_W-1:0]   gidx, gidx_nxt;
  logic [LEN_W-1:0]   rem, rem_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [N_REQ-1:0]   gnt_nxt;
  logic               tx_ack_nxt, rx_valid_nxt, done_nxt, err_nxt, m_start_nxt;
  logic [BYTE_W-1:0]  rx_data_nxt, m_dout_nxt;

  logic [N_REQ-1:0]   win_oh;
  logic [IDX_W-1:0]   win_idx;
  logic               win_vld;
  logic [LEN_W-1:0]   win_len;

  assign dbg_state = state;

  rr_arb_m #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req     (REQ),
    .ptr     (ptr),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .win_vld (win_vld)
  );

  assign win_len = LEN[int'(win_idx)*LEN_W +: LEN_W];

  // Requester after idx, wrapping; the served requester drops to lowest priority.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    if (int'(idx) == N_REQ - 1) return '0;
    return idx + IDX_W'(1);
  endfunction

  // Next-state and next-output logic for the byte sequencer.
  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    gidx_nxt     = gidx;
    rem_nxt      = rem;
    cnt_nxt      = cnt;
    gnt_nxt      = GNT;
    tx_ack_nxt   = 1'b0;
    rx_valid_nxt = 1'b0;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    m_start_nxt  = 1'b0;
    rx_data_nxt  = RX_DATA;
    m_dout_nxt   = M_DOUT;
    case (state)
      IDLE: begin
        // CS high guard keeps us off a master still finishing an orphaned byte.
        if (win_vld && M_CS) begin
          if (win_len == '0) begin
            done_nxt = 1'b1;
            err_nxt  = 1'b1;
            ptr_nxt  = next_idx(win_idx);
          end else begin
            gnt_nxt   = win_oh;
            gidx_nxt  = win_idx;
            rem_nxt   = win_len;
            state_nxt = LOAD;
          end
        end
      end
      LOAD: begin
        m_dout_nxt  = TX_DATA[int'(gidx)*BYTE_W +: BYTE_W];
        m_start_nxt = 1'b1;
        tx_ack_nxt  = 1'b1;
        cnt_nxt     = '0;
        state_nxt   = WAIT_LO;
      end
      WAIT_LO: begin
        if (!M_CS) begin
          cnt_nxt   = '0;
          state_nxt = WAIT_HI;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          done_nxt  = 1'b1;
          err_nxt   = 1'b1;
          gnt_nxt   = '0;
          ptr_nxt   = next_idx(gidx);
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      WAIT_HI: begin
        if (M_CS) begin
          state_nxt = CAP;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          done_nxt  = 1'b1;
          err_nxt   = 1'b1;
          gnt_nxt   = '0;
          ptr_nxt   = next_idx(gidx);
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      CAP: begin
        rx_data_nxt  = M_DIN;
        rx_valid_nxt = 1'b1;
        rem_nxt      = rem - LEN_W'(1);
        if (rem != LEN_W'(1)) begin
          state_nxt = LOAD;
        end else begin
          done_nxt  = 1'b1;
          gnt_nxt   = '0;
          ptr_nxt   = next_idx(gidx);
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      ptr      <= '0;
      gidx     <= '0;
      rem      <= '0;
      cnt      <= '0;
      GNT      <= '0;
      TX_ACK   <= 1'b0;
      RX_DATA  <= '0;
      RX_VALID <= 1'b0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
      M_START  <= 1'b0;
      M_DOUT   <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      gidx     <= gidx_nxt;
      rem      <= rem_nxt;
      cnt      <= cnt_nxt;
      GNT      <= gnt_nxt;
      TX_ACK   <= tx_ack_nxt;
      RX_DATA  <= rx_data_nxt;
      RX_VALID <= rx_valid_nxt;
      DONE     <= done_nxt;
      ERR      <= err_nxt;
      M_START  <= m_start_nxt;
      M_DOUT   <= m_dout_nxt;
    end
  end

endmodule

// File: tb/tb_spi_arb_m.sv
// Bench for spi_arb_m: behavioural SPI master on the M_* side, two requesters.
module tb_spi_arb_m;
  import spi_pkg::*;

  localparam int N_REQ   = 2;
  localparam int LEN_W   = 3;
  localparam int TIMEOUT = 64;

  logic                    CLK, RST;
  logic [N_REQ-1:0]        REQ;
  logic [N_REQ*LEN_W-1:0]  LEN;
  logic [N_REQ*8-1:0]      TX_DATA;
  logic [N_REQ-1:0]        GNT;
  logic                    TX_ACK, RX_VALID, DONE, ERR, M_START, M_CS;
  logic [7:0]              RX_DATA, M_DOUT, M_DIN;
  state_t                  dbg_state;

  spi_arb_m #(.N_REQ(N_REQ), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .LEN(LEN), .TX_DATA(TX_DATA),
    .GNT(GNT), .TX_ACK(TX_ACK), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .DONE(DONE), .ERR(ERR), .M_START(M_START), .M_DOUT(M_DOUT),
    .M_DIN(M_DIN), .M_CS(M_CS), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];      // bytes the DUT must return on RX_DATA
  logic [7:0] exp_tx_q[$];   // bytes the slave must see on M_DOUT, in order
  logic [7:0] slave_tx_q[$]; // bytes the slave will send back
  logic [7:0] tx_src0[$], tx_src1[$];
  logic [1:0] gnt_log[$];
  bit   master_en = 1'b1;
  int   cs_lo_fix = 0;
  int   master_bytes = 0;
  int   start_cnt = 0, rx_cnt = 0, done_cnt = 0, multi_gnt = 0;
  logic [1:0] prev_gnt = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural SPI master ----------------
  initial begin
    logic [7:0] b;
    M_CS  = 1'b1;
    M_DIN = '0;
    forever begin
      @(negedge CLK);
      if (master_en && M_START) begin
        chk("slave_q_nonempty", 32'(exp_tx_q.size() != 0), 1);
        if (exp_tx_q.size() != 0) chk("slave_din", 32'(M_DOUT), 32'(exp_tx_q.pop_front()));
        repeat ($urandom_range(0, 2)) @(negedge CLK);
        M_CS = 1'b0;
        repeat (cs_lo_fix != 0 ? cs_lo_fix : int'($urandom_range(2, 5))) @(negedge CLK);
        b = (slave_tx_q.size() != 0) ? slave_tx_q.pop_front() : 8'($urandom_range(0, 255));
        M_DIN = b;
        exp_q.push_back(b);
        M_CS = 1'b1;
        master_bytes++;
      end
    end
  end

  // ---------------- output monitor ----------------
  always @(negedge CLK) begin
    if (M_START) start_cnt++;
    if (DONE) done_cnt++;
    if ($countones(GNT) > 1) multi_gnt++;
    if (GNT != '0 && GNT != prev_gnt) gnt_log.push_back(GNT);
    prev_gnt = GNT;
    if (RX_VALID) begin
      rx_cnt++;
      chk("rx_q_nonempty", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("rx_data", 32'(RX_DATA), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_gnt"},    32'(GNT), 0);
    chk({tag, "_txack"},  32'(TX_ACK), 0);
    chk({tag, "_rxdata"}, 32'(RX_DATA), 0);
    chk({tag, "_rxvld"},  32'(RX_VALID), 0);
    chk({tag, "_done"},   32'(DONE), 0);
    chk({tag, "_err"},    32'(ERR), 0);
    chk({tag, "_mstart"}, 32'(M_START), 0);
    chk({tag, "_mdout"},  32'(M_DOUT), 0);
    chk({tag, "_state"},  32'(dbg_state), 32'(IDLE));
  endtask

  // Feeds TX bytes on TX_ACK until DONE or the budget runs out.
  task automatic run_txn(input int budget, output bit done_seen, output bit err_seen);
    done_seen = 1'b0;
    err_seen  = 1'b0;
    for (int n = 0; n < budget && !done_seen; n++) begin
      @(negedge CLK);
      if (TX_ACK) begin
        if (GNT[0] && tx_src0.size() != 0) TX_DATA[7:0]  = tx_src0.pop_front();
        if (GNT[1] && tx_src1.size() != 0) TX_DATA[15:8] = tx_src1.pop_front();
      end
      if (DONE) begin
        done_seen = 1'b1;
        err_seen  = ERR;
      end
    end
    chk("txn_done", 32'(done_seen), 1);
  endtask

  // ---------------- tests ----------------
  initial begin
    bit d, e;
    int s0, r0, dn0, mb0, n;
    RST = 1'b1; REQ = '0; LEN = '0; TX_DATA = '0;
    do_reset();
    check_idle_outputs("reset");

    // Single byte from requester 0.
    s0 = start_cnt; r0 = rx_cnt;
    slave_tx_q.push_back(8'h34);
    exp_tx_q.push_back(8'h56);
    LEN = {3'd0, 3'd1}; TX_DATA = {8'h00, 8'h56}; REQ = 2'b01;
    run_txn(100, d, e);
    REQ = 2'b00;
    chk("single_err", 32'(e), 0);
    @(negedge CLK);
    chk("single_starts", 32'(start_cnt - s0), 1);
    chk("single_rx", 32'(rx_cnt - r0), 1);
    chk("single_gnt_off", 32'(GNT), 0);

    // Multi-byte from requester 1, bytes advanced on TX_ACK.
    s0 = start_cnt; r0 = rx_cnt; dn0 = done_cnt;
    exp_tx_q.push_back(8'hA1); exp_tx_q.push_back(8'hA2); exp_tx_q.push_back(8'hA3);
    tx_src1.push_back(8'hA2); tx_src1.push_back(8'hA3);
    LEN = {3'd3, 3'd0}; TX_DATA = {8'hA1, 8'h00}; REQ = 2'b10;
    run_txn(200, d, e);
    REQ = 2'b00;
    chk("multi_err", 32'(e), 0);
    @(negedge CLK);
    chk("multi_starts", 32'(start_cnt - s0), 3);
    chk("multi_rx", 32'(rx_cnt - r0), 3);
    chk("multi_done_once", 32'(done_cnt - dn0), 1);

    // Contention: both request from reset, grants must alternate 01,10,01,10.
    do_reset();
    gnt_log.delete();
    multi_gnt = 0;
    exp_tx_q.push_back(8'h10); exp_tx_q.push_back(8'h20);
    exp_tx_q.push_back(8'h11); exp_tx_q.push_back(8'h21);
    tx_src0.push_back(8'h11); tx_src1.push_back(8'h21);
    LEN = {3'd1, 3'd1}; TX_DATA = {8'h20, 8'h10}; REQ = 2'b11;
    for (int k = 0; k < 4; k++) begin
      run_txn(100, d, e);
      chk("cont_err", 32'(e), 0);
    end
    REQ = 2'b00;
    @(negedge CLK);
    chk("cont_nlog", 32'(gnt_log.size()), 4);
    if (gnt_log.size() == 4) begin
      chk("cont_g0", 32'(gnt_log[0]), 32'h1);
      chk("cont_g1", 32'(gnt_log[1]), 32'h2);
      chk("cont_g2", 32'(gnt_log[2]), 32'h1);
      chk("cont_g3", 32'(gnt_log[3]), 32'h2);
    end
    chk("cont_onehot", 32'(multi_gnt), 0);

    // LEN=0 on requester 0: reject, then requester 1 must win next.
    do_reset();
    s0 = start_cnt;
    LEN = {3'd1, 3'd0}; TX_DATA = {8'h5A, 8'h99}; REQ = 2'b11;
    run_txn(10, d, e);
    chk("len0_err", 32'(e), 1);
    @(negedge CLK);
    chk("len0_gnt_next", 32'(GNT), 32'h2);
    chk("len0_done_1cyc", 32'(DONE), 0);
    chk("len0_err_1cyc", 32'(ERR), 0);
    chk("len0_no_start", 32'(start_cnt - s0), 0);
    REQ = 2'b00;
    exp_tx_q.push_back(8'h5A);
    run_txn(100, d, e);
    chk("len0_r1_err", 32'(e), 0);

    // Timeout: master disconnected, CS stays high.
    do_reset();
    master_en = 1'b0;
    s0 = start_cnt; r0 = rx_cnt;
    LEN = {3'd0, 3'd2}; TX_DATA = {8'h00, 8'hC3}; REQ = 2'b01;
    n = 0;
    while (!M_START && n < 10) begin @(negedge CLK); n++; end
    chk("tmo_start_seen", 32'(M_START), 1);
    n = 0;
    do begin @(negedge CLK); n++; end while (!DONE && n < 3 * TIMEOUT);
    REQ = 2'b00;
    chk("tmo_cycles", 32'(n), 32'(TIMEOUT));
    chk("tmo_err", 32'(ERR), 1);
    chk("tmo_gnt_off", 32'(GNT), 0);
    @(negedge CLK);
    chk("tmo_no_rx", 32'(rx_cnt - r0), 0);
    chk("tmo_one_start", 32'(start_cnt - s0), 1);
    master_en = 1'b1;

    // Reset mid-byte: no grant until the orphaned byte ends with CS high.
    do_reset();
    cs_lo_fix = 8;
    exp_tx_q.push_back(8'h77);
    LEN = {3'd0, 3'd1}; TX_DATA = {8'h00, 8'h77}; REQ = 2'b01;
    n = 0;
    while (M_CS && n < 20) begin @(negedge CLK); n++; end
    mb0 = master_bytes;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check_idle_outputs("midrst");
    n = 0;
    while (GNT == '0 && n < 40) begin @(negedge CLK); n++; end
    chk("midrst_gnt", 32'(GNT), 32'h1);
    chk("midrst_orphan_done", 32'(master_bytes - mb0), 1);
    exp_q.delete();
    exp_tx_q.push_back(8'h77);
    r0 = rx_cnt;
    run_txn(100, d, e);
    REQ = 2'b00;
    chk("midrst_err", 32'(e), 0);
    @(negedge CLK);
    chk("midrst_rx", 32'(rx_cnt - r0), 1);
    cs_lo_fix = 0;

    repeat (5) @(negedge CLK);
    chk("end_rx_q_empty", 32'(exp_q.size()), 0);
    chk("end_tx_q_empty", 32'(exp_tx_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
